// File: rtl/inverse_iter_ctrl.sv
// Iteration controller around the Gauss-Jordan column kernel: accepts a matrix, issues N kernel passes, returns the inverse.
// Optional `INV_UNPERMUTE_EN: register the column unscramble of the result on entry to OUT.
module inverse_iter_ctrl #(
   parameter int unsigned MAT_SIZE = 4,
   parameter int unsigned DATWIDTH = 32,
   parameter int unsigned TIMEOUT  = 1024,
   localparam int unsigned CW      = $clog2(MAT_SIZE) + 1
) (
   input  logic                                             clk,
   input  logic                                             reset,
   input  logic [MAT_SIZE-1:0][MAT_SIZE-1:0][DATWIDTH-1:0] s_mat,
   input  logic                                             s_vld,
   output logic                                             s_rdy,
   output logic [MAT_SIZE-1:0][MAT_SIZE-1:0][DATWIDTH-1:0] k_mat_in,
   output logic                                             k_in_vld,
   output logic [CW-1:0]                                    k_op_cnt,
   output logic [MAT_SIZE-1:0][CW-1:0]                      k_per_in,
   output logic                                             k_err_in,
   input  logic [MAT_SIZE-1:0][MAT_SIZE-1:0][DATWIDTH-1:0] k_mat_out,
   input  logic                                             k_out_vld,
   input  logic [CW-1:0]                                    k_next_op_cnt,
   input  logic [MAT_SIZE-1:0][CW-1:0]                      k_per_out,
   input  logic                                             k_err_out,
   output logic [MAT_SIZE-1:0][MAT_SIZE-1:0][DATWIDTH-1:0] m_mat,
   output logic [MAT_SIZE-1:0][CW-1:0]                      m_perm,
   output logic                                             m_err,
   output logic                                             m_vld,
   input  logic                                             m_rdy
);

   localparam int unsigned WW = $clog2(TIMEOUT) + 1;

   typedef logic [MAT_SIZE-1:0][MAT_SIZE-1:0][DATWIDTH-1:0] mat_t;
   typedef logic [MAT_SIZE-1:0][CW-1:0]                      perm_t;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_e;

   state_e          state_q, state_d;
   mat_t            work_q, work_d;
   perm_t           perm_q, perm_d;
   logic [CW-1:0]   iter_q, iter_d;
   logic            err_q, err_d;
   logic [WW-1:0]   wdog_q, wdog_d;
   mat_t            m_mat_q, m_mat_d;
   perm_t           m_perm_q, m_perm_d;
   logic            m_err_q, m_err_d;

   perm_t           ident_perm;
   logic            last_pass;
   logic            bad_next;
   logic            timed_out;
   logic            enter_out;

   always_comb begin
      ident_perm = '0;
      for (int unsigned i = 0; i < MAT_SIZE; i++) begin
         ident_perm[i] = CW'(i);
      end
   end

   assign last_pass = (k_next_op_cnt == CW'(MAT_SIZE));
   assign bad_next  = (k_next_op_cnt <= iter_q) || (k_next_op_cnt > CW'(MAT_SIZE));
   assign timed_out = (wdog_q >= WW'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (s_vld) state_d = ISSUE;
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (k_out_vld) begin
               state_d = (bad_next || last_pass) ? OUT : ISSUE;
            end else if (timed_out) begin
               state_d = OUT;
            end
         end
         OUT:   if (m_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      s_rdy    = (state_q == IDLE);
      k_in_vld = (state_q == ISSUE);
      m_vld    = (state_q == OUT);
   end

   assign enter_out = (state_q == WAIT) && (state_d == OUT);

   // Watchdog is 0 while in ISSUE, so a silent kernel yields m_vld TIMEOUT cycles after the issue strobe
   always_comb begin
      work_d   = work_q;
      perm_d   = perm_q;
      iter_d   = iter_q;
      err_d    = err_q;
      wdog_d   = wdog_q;
      m_mat_d  = m_mat_q;
      m_perm_d = m_perm_q;
      m_err_d  = m_err_q;
      case (state_q)
         IDLE: begin
            if (s_vld) begin
               work_d = s_mat;
               perm_d = ident_perm;
               iter_d = '0;
               err_d  = 1'b0;
               wdog_d = '0;
            end
         end
         ISSUE: wdog_d = wdog_q + 1'b1;
         WAIT: begin
            wdog_d = wdog_q + 1'b1;
            if (k_out_vld) begin
               work_d = k_mat_out;
               perm_d = k_per_out;
               err_d  = err_q | k_err_out | bad_next;
               if (!bad_next && !last_pass) begin
                  iter_d = k_next_op_cnt;
                  wdog_d = '0;
               end
            end else if (timed_out) begin
               err_d = 1'b1;
            end
         end
         default: ;
      endcase

      if (enter_out) begin
         m_perm_d = perm_d;
         m_err_d  = err_d;
`ifdef INV_UNPERMUTE_EN
         // Gather form of m_mat[r][perm[c]] = work[r][c]
         m_mat_d = '0;
         for (int unsigned r = 0; r < MAT_SIZE; r++) begin
            for (int unsigned c = 0; c < MAT_SIZE; c++) begin
               for (int unsigned t = 0; t < MAT_SIZE; t++) begin
                  if (perm_d[c] == CW'(t)) m_mat_d[r][t] = work_d[r][c];
               end
            end
         end
`else
         m_mat_d = work_d;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         work_q   <= '0;
         perm_q   <= ident_perm;
         iter_q   <= '0;
         err_q    <= 1'b0;
         wdog_q   <= '0;
         m_mat_q  <= '0;
         m_perm_q <= ident_perm;
         m_err_q  <= 1'b0;
      end else begin
         work_q   <= work_d;
         perm_q   <= perm_d;
         iter_q   <= iter_d;
         err_q    <= err_d;
         wdog_q   <= wdog_d;
         m_mat_q  <= m_mat_d;
         m_perm_q <= m_perm_d;
         m_err_q  <= m_err_d;
      end
   end

   assign k_mat_in = work_q;
   assign k_per_in = perm_q;
   assign k_op_cnt = iter_q;
   assign k_err_in = err_q;
   assign m_mat    = m_mat_q;
   assign m_perm   = m_perm_q;
   assign m_err    = m_err_q;

endmodule

// File: tb/tb_inverse_iter_ctrl.sv
// Bench for inverse_iter_ctrl: table-driven matrices against a kernel model, scoreboard on the output handshake,
// plus timeout, backpressure and reset-in-WAIT sequences. Expectations follow `INV_UNPERMUTE_EN.
module tb_inverse_iter_ctrl;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int CW = 3;
   localparam int TO = 16;

   typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;
   typedef logic [N-1:0][CW-1:0]        perm_t;

   typedef struct {
      mat_t  mat;
      perm_t perm;
      logic  err;
   } exp_t;

   typedef struct {
      logic [DW-1:0] diag;
      logic [DW-1:0] k00;
      int            kperm[N];
      int            err_iter;
      int            bad_iter;
      logic          exp_err;
      int            exp_issues;
      int            hold;
   } vec_t;

   logic  clk = 1'b0;
   logic  reset = 1'b0;
   mat_t  s_mat = '0;
   logic  s_vld = 1'b0;
   logic  s_rdy;
   mat_t  k_mat_in;
   logic  k_in_vld;
   logic [CW-1:0] k_op_cnt;
   perm_t k_per_in;
   logic  k_err_in;
   mat_t  k_mat_out = '0;
   logic  k_out_vld = 1'b0;
   logic [CW-1:0] k_next_op_cnt = '0;
   perm_t k_per_out = '0;
   logic  k_err_out = 1'b0;
   mat_t  m_mat;
   perm_t m_perm;
   logic  m_err;
   logic  m_vld;
   logic  m_rdy = 1'b0;

   int    checks = 0;
   int    failures = 0;
   int    issue_cnt = 0;
   exp_t  sb[$];
   vec_t  tv[5];
   perm_t id_p;

   inverse_iter_ctrl #(.MAT_SIZE(N), .DATWIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .s_mat(s_mat), .s_vld(s_vld), .s_rdy(s_rdy),
      .k_mat_in(k_mat_in), .k_in_vld(k_in_vld), .k_op_cnt(k_op_cnt),
      .k_per_in(k_per_in), .k_err_in(k_err_in),
      .k_mat_out(k_mat_out), .k_out_vld(k_out_vld), .k_next_op_cnt(k_next_op_cnt),
      .k_per_out(k_per_out), .k_err_out(k_err_out),
      .m_mat(m_mat), .m_perm(m_perm), .m_err(m_err), .m_vld(m_vld), .m_rdy(m_rdy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model_out(input mat_t w, input perm_t p, input logic e);
      exp_t o;
      o.perm = p;
      o.err  = e;
`ifdef INV_UNPERMUTE_EN
      o.mat = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            o.mat[r][p[c][1:0]] = w[r][c];
`else
      o.mat = w;
`endif
      return o;
   endfunction

   task automatic set_vec(input int i, input logic [DW-1:0] diag, input logic [DW-1:0] k00,
                          input int p0, input int p1, input int p2, input int p3,
                          input int err_iter, input int bad_iter, input logic exp_err,
                          input int exp_issues, input int hold);
      tv[i].diag = diag;  tv[i].k00 = k00;
      tv[i].kperm[0] = p0; tv[i].kperm[1] = p1; tv[i].kperm[2] = p2; tv[i].kperm[3] = p3;
      tv[i].err_iter = err_iter; tv[i].bad_iter = bad_iter;
      tv[i].exp_err = exp_err; tv[i].exp_issues = exp_issues; tv[i].hold = hold;
   endtask

   task automatic check_reset_vals();
      check("rst_s_rdy",    512'(s_rdy),    512'(1));
      check("rst_k_in_vld", 512'(k_in_vld), 512'(0));
      check("rst_k_op_cnt", 512'(k_op_cnt), 512'(0));
      check("rst_k_err_in", 512'(k_err_in), 512'(0));
      check("rst_k_mat_in", 512'(k_mat_in), 512'(0));
      check("rst_k_per_in", 512'(k_per_in), 512'(id_p));
      check("rst_m_mat",    512'(m_mat),    512'(0));
      check("rst_m_perm",   512'(m_perm),   512'(id_p));
      check("rst_m_err",    512'(m_err),    512'(0));
      check("rst_m_vld",    512'(m_vld),    512'(0));
   endtask

   task automatic run_vec(input int v);
      mat_t  in_m, r_m;
      perm_t kp;
      exp_t  e;
      int    n;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            in_m[r][c] = (r == c) ? tv[v].diag : '0;
            r_m[r][c]  = (r == c) ? tv[v].diag : '0;
         end
      r_m[0][0] = tv[v].k00;
      for (int i = 0; i < N; i++) kp[i] = CW'(tv[v].kperm[i]);
      e = model_out(r_m, kp, tv[v].exp_err);
      sb.push_back(e);

      check("idle_s_rdy", 512'(s_rdy), 512'(1));
      issue_cnt = 0;
      s_mat = in_m;
      s_vld = 1'b1;
      step();
      s_vld = 1'b0;
      for (int op = 0; op < tv[v].exp_issues; op++) begin
         n = 0;
         while (!k_in_vld && n < 8) begin step(); n++; end
         check("issue_latency", 512'(n), 512'(0));
         check("k_op_cnt", 512'(k_op_cnt), 512'(op));
         check("k_err_in", 512'(k_err_in), 512'((tv[v].err_iter >= 0) && (op > tv[v].err_iter)));
         check("k_mat_in00", 512'(k_mat_in[0][0]), 512'((op == 0) ? tv[v].diag : tv[v].k00));
         check("k_per_in", 512'(k_per_in), 512'((op == 0) ? id_p : kp));
         repeat (1 + op % 3) step();
         k_out_vld     = 1'b1;
         k_mat_out     = r_m;
         k_per_out     = kp;
         k_err_out     = (op == tv[v].err_iter);
         k_next_op_cnt = CW'((op == tv[v].bad_iter) ? op : op + 1);
         step();
         k_out_vld = 1'b0;
         k_err_out = 1'b0;
      end
      check("final_latency_m_vld", 512'(m_vld), 512'(1));
      check("issue_count", 512'(issue_cnt), 512'(tv[v].exp_issues));

      if (tv[v].hold > 0) begin
         s_mat = '1;
         s_vld = 1'b1;
         for (int h = 0; h < tv[v].hold; h++) begin
            step();
            check("bp_m_vld", 512'(m_vld), 512'(1));
            check("bp_s_rdy", 512'(s_rdy), 512'(0));
            check("bp_k_in_vld", 512'(k_in_vld), 512'(0));
            check("bp_m_mat", 512'(m_mat), 512'(e.mat));
            check("bp_m_perm_err", 512'({m_perm, m_err}), 512'({e.perm, e.err}));
         end
         s_vld = 1'b0;
         check("bp_issue_count", 512'(issue_cnt), 512'(tv[v].exp_issues));
      end

      m_rdy = 1'b1;
      step();
      m_rdy = 1'b0;
      check("post_out_s_rdy", 512'(s_rdy), 512'(1));
      check("post_out_m_vld", 512'(m_vld), 512'(0));
   endtask

   // Scoreboard pops on each accepted output
   always @(negedge clk) begin
      if (!reset && k_in_vld) issue_cnt++;
      if (!reset && m_vld && m_rdy) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_output actual=m_vld required=no_output");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_m_mat",  512'(m_mat),  512'(e.mat));
            check("out_m_perm", 512'(m_perm), 512'(e.perm));
            check("out_m_err",  512'(m_err),  512'(e.err));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "global timeout");
   end

   initial begin
      mat_t tm;
      int   n;
      for (int i = 0; i < N; i++) id_p[i] = CW'(i);

      set_vec(0, 32'h0001_0000, 32'h0001_0000, 0, 1, 2, 3, -1, -1, 1'b0, 4, 0);  // identity
      set_vec(1, 32'h0001_0000, 32'h0000_1234, 1, 0, 3, 2, -1, -1, 1'b0, 4, 10); // permuted + backpressure
      set_vec(2, 32'h0001_0000, 32'h0001_0000, 0, 1, 2, 3,  1, -1, 1'b1, 4, 0);  // kernel error on pass 1
      set_vec(3, 32'hFFFF_0000, 32'hFFFF_8000, 3, 2, 1, 0, -1, -1, 1'b0, 4, 0);  // negative values
      set_vec(4, 32'h0002_0000, 32'h0002_0000, 0, 1, 2, 3, -1,  1, 1'b1, 2, 0);  // next <= iteration

      #2 reset = 1'b1;
      step(); step();
      check_reset_vals();
      reset = 1'b0;
      step();

      for (int v = 0; v < 5; v++) run_vec(v);

      // Silent kernel: watchdog expiry
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) tm[r][c] = DW'(r * 16 + c + 1);
      sb.push_back(model_out(tm, id_p, 1'b1));
      issue_cnt = 0;
      s_mat = tm;
      s_vld = 1'b1;
      step();
      s_vld = 1'b0;
      check("to_k_in_vld", 512'(k_in_vld), 512'(1));
      n = 0;
      while (!m_vld && n < 40) begin step(); n++; end
      check("to_m_vld_delay", 512'(n), 512'(TO));
      check("to_issue_count", 512'(issue_cnt), 512'(1));
      m_rdy = 1'b1;
      step();
      m_rdy = 1'b0;
      check("to_s_rdy", 512'(s_rdy), 512'(1));

      // Reset while waiting on the kernel, then a stale result
      s_mat = tm;
      s_vld = 1'b1;
      step();
      s_vld = 1'b0;
      step();
      reset = 1'b1;
      #1;
      check_reset_vals();
      step();
      reset = 1'b0;
      k_out_vld     = 1'b1;
      k_mat_out     = tm;
      k_per_out     = '0;
      k_err_out     = 1'b1;
      k_next_op_cnt = CW'(N);
      step();
      k_out_vld = 1'b0;
      k_err_out = 1'b0;
      step();
      check("late_s_rdy", 512'(s_rdy), 512'(1));
      check("late_m_vld", 512'(m_vld), 512'(0));
      check("late_k_in_vld", 512'(k_in_vld), 512'(0));
      check("late_m_mat", 512'(m_mat), 512'(0));
      run_vec(0);

      step();
      check("sb_drained", 512'(sb.size()), 512'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
